// File: rtl/rv_lsu.sv
// RV64 load/store unit: funct3/alignment check, lane-steered 8-byte bus requests, load extension.
// Latency accept->resp: error 1, store 2 + grant waits, load 3 + grant/rvalid waits; req_ready_o low while busy.
module rv_lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            req_ready_o,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [7:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [2:0]      f3_q;
    logic [2:0]      off_q;

    logic [2:0]      off;
    logic            f3_bad;
    logic            misal;
    logic [7:0]      be_base;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_ext;

    assign off         = req_addr_i[2:0];
    assign req_ready_o = (state == IDLE);
    assign f3_bad      = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);

    // Size is funct3[1:0] for both loads and stores.
    always_comb begin
        misal   = 1'b0;
        be_base = 8'hFF;
        case (req_funct3_i[1:0])
            2'd0: begin misal = 1'b0;        be_base = 8'h01; end
            2'd1: begin misal = off[0];      be_base = 8'h03; end
            2'd2: begin misal = |off[1:0];   be_base = 8'h0F; end
            default: begin misal = |off;     be_base = 8'hFF; end
        endcase
    end

    assign shifted = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ld_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  ld_ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (f3_bad || misal) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                        end else begin
                            state       <= REQ;
                            f3_q        <= req_funct3_i;
                            off_q       <= off;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {req_addr_i[XLEN-1:3], 3'b000};
                            mem_be_o    <= be_base << off;
                            mem_wdata_o <= req_wdata_i << {off, 3'b000};
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            state        <= IDLE;
                            resp_valid_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= ld_ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized bench for rv_lsu with a byte-level reference model and a bench-driven memory responder.
module tb_rv_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    rv_lsu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference load result: pick nb bytes at offset off, then extend by signedness.
    function automatic logic [63:0] ld_model(input logic [2:0] f3, input int off, input logic [63:0] rd);
        int          nb;
        logic [63:0] v;
        logic [63:0] mask;
        nb = 1 << f3[1:0];
        v = 64'h0;
        for (int i = 0; i < nb; i++)
            v[8*i +: 8] = rd[8*(off+i) +: 8];
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 64'd1);
        if (!f3[2] && v[8*nb-1])
            v = v | ~mask;
        return v;
    endfunction

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int gd, input int rdly, input bit junk);
        int          off, nb, lat;
        bit          legal;
        logic [7:0]  e_be;
        logic [63:0] e_rd;
        off   = int'(addr[2:0]);
        nb    = 1 << f3[1:0];
        legal = (we ? (f3 < 3'd4) : (f3 != 3'd7)) && (off % nb == 0);
        e_be  = 8'(((1 << nb) - 1) << off);
        e_rd  = ld_model(f3, off, rd);

        chk("ready_before_accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        if (!legal) begin
            chk("err_valid", 64'(resp_valid), 64'd1);
            chk("err_flag", 64'(resp_err), 64'd1);
            chk("err_rdata", resp_rdata, 64'd0);
            chk("err_no_bus", 64'(mem_req), 64'd0);
            chk("err_ready", 64'(req_ready), 64'd1);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            mem_gnt = (k == gd);
            if (junk && k < gd) begin
                req_valid = 1'($urandom_range(1));
                req_we = 1'($urandom_range(1));
                req_funct3 = 3'($urandom_range(7));
                req_addr = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
            end else begin
                req_valid = 1'b0;
            end
            chk("mem_req_held", 64'(mem_req), 64'd1);
            chk("mem_addr", mem_addr, addr & ~64'h7);
            chk("mem_be", 64'(mem_be), 64'(e_be));
            chk("mem_we", 64'(mem_we), 64'(we));
            if (we) chk("mem_wdata", mem_wdata, wd << (8*off));
            chk("busy_ready", 64'(req_ready), 64'd0);
            chk("busy_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        mem_gnt = 1'b0;
        req_valid = 1'b0;
        chk("req_drop_after_gnt", 64'(mem_req), 64'd0);
        if (!we) begin
            chk("load_no_early_resp", 64'(resp_valid), 64'd0);
            for (int j = 0; j <= rdly; j++) begin
                mem_rvalid = (j == rdly);
                mem_rdata = (j == rdly) ? rd : {$urandom, $urandom};
                @(posedge clk); #1;
                lat++;
                if (j < rdly) chk("wait_no_resp", 64'(resp_valid), 64'd0);
            end
            mem_rvalid = 1'b0;
            chk("load_valid", 64'(resp_valid), 64'd1);
            chk("load_rdata", resp_rdata, e_rd);
            chk("load_lat", 64'(lat), 64'(3 + gd + rdly));
        end else begin
            chk("store_valid", 64'(resp_valid), 64'd1);
            chk("store_rdata", resp_rdata, 64'd0);
            chk("store_lat", 64'(lat), 64'(2 + gd));
        end
        chk("resp_err_clear", 64'(resp_err), 64'd0);
        chk("ready_in_resp", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        do_txn(1'b0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
        do_txn(1'b0, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
        do_txn(1'b0, 3'b000, 64'h1002, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0);
        do_txn(1'b1, 3'b001, 64'h2006, 64'h1234, 64'h0, 0, 0, 0);
        do_txn(1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 0, 0, 0);
        do_txn(1'b1, 3'b100, 64'h3000, 64'h55, 64'h0, 0, 0, 0);
        do_txn(1'b0, 3'b111, 64'h3000, 64'h0, 64'h0, 0, 0, 0);
        do_txn(1'b0, 3'b011, 64'h4008, 64'h0, 64'hDEAD_BEEF_0123_4567, 3, 0, 1);
        do_txn(1'b1, 3'b011, 64'h4010, 64'hCAFE_F00D_8765_4321, 64'h0, 2, 0, 1);

        // Reset while a load waits for read data
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h5000;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_addr", mem_addr, 64'd0);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_mem_wdata", mem_wdata, 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_resp_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_ignored", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic; zero gaps give back-to-back acceptance in the response cycle
        for (int t = 0; t < 250; t++) begin
            f3 = 3'($urandom_range(7));
            a  = {$urandom, $urandom};
            if ($urandom_range(3) != 0)
                a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
            do_txn(1'($urandom_range(1)), f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)));
            if ($urandom_range(2) == 0) begin
                for (int g = 0; g < int'($urandom_range(2)); g++) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
